// File: rtl/hyperbus_pkg.sv
// hyperbus_pkg: shared HyperBus types for the transaction arbiter slice.
//   hyper_tf_t  - transaction descriptor (write flag, address space, burst)
//   hyper_cfg_t - PHY timing/config word
//   hyper_tx_t  - write beat (data, strb, last)
//   hyper_rx_t  - read beat (data, last, error)
//   arb_state_e - arbiter FSM states
package hyperbus_pkg;

    localparam int unsigned HyperDataW  = 32;  // dual-PHY width
    localparam int unsigned HyperStrbW  = HyperDataW / 8;
    localparam int unsigned HyperAddrW  = 32;
    localparam int unsigned HyperBurstW = 16;

    typedef struct packed {
        logic                   write;
        logic                   address_space;
        logic                   burst_type;
        logic [HyperAddrW-1:0]  address;
        logic [HyperBurstW-1:0] burst;
    } hyper_tf_t;

    typedef struct packed {
        logic [3:0]  t_latency_access;
        logic        en_latency_additional;
        logic [15:0] t_burst_max;
        logic [3:0]  t_read_write_recovery;
        logic [3:0]  t_rx_clk_delay;
        logic [3:0]  t_tx_clk_delay;
        logic        phys_in_use;
    } hyper_cfg_t;

    typedef struct packed {
        logic [HyperDataW-1:0] data;
        logic [HyperStrbW-1:0] strb;
        logic                  last;
    } hyper_tx_t;

    typedef struct packed {
        logic [HyperDataW-1:0] data;
        logic                  last;
        logic                  error;
    } hyper_rx_t;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_ISSUE  = 3'd1,
        ARB_WRITE  = 3'd2,
        ARB_WAIT_B = 3'd3,
        ARB_READ   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/hyperbus_rr_select.sv
// hyperbus_rr_select: combinational round-robin pick.
//   valid_i - request vector
//   ptr_i   - search start index (must be < NumReq)
//   grant_o - one-hot grant, all zero when nothing is valid
//   idx_o   - index of the granted requester (0 when none)
module hyperbus_rr_select #(
    parameter  int unsigned NumReq = 2,
    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] grant_o,
    output logic [IdxW-1:0]   idx_o
);

    int unsigned     w_sum;
    logic [IdxW-1:0] w_cand;
    logic            w_found;

    // Scan ptr, ptr+1, ... modulo NumReq; first valid wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            w_sum = 32'(ptr_i) + i;
            if (w_sum >= NumReq) begin
                w_sum = w_sum - NumReq;
            end
            w_cand = IdxW'(w_sum);
            if (!w_found && valid_i[w_cand]) begin
                w_found         = 1'b1;
                grant_o[w_cand] = 1'b1;
                idx_o           = w_cand;
            end
        end
    end

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// hyperbus_trans_arbiter: shares one HyperBus PHY between NumReq requesters.
// A whole transaction (trans + tx/rx + b) is granted at a time, round-robin.
// Optional macro HYPERBUS_ARB_STATS_EN adds per-requester saturating grant
// counters on grant_cnt_o.
// Ports:
//   clk_i, rst_i (sync, active high)
//   req_trans_*  - per-requester transaction channel (valid/ready/desc/cs)
//   req_tx_*     - per-requester write-data channel
//   req_rx_*     - read-data channel, data broadcast, valid per requester
//   req_b_*      - write response, error broadcast, valid per requester
//   phy_*        - single PHY-side trans/tx/rx/b channels
//   owner_o      - current owner index, busy_o - FSM not idle
module hyperbus_trans_arbiter
    import hyperbus_pkg::*;
#(
    parameter  int unsigned NumReq   = 2,
    parameter  int unsigned NumChips = 2,
    localparam int unsigned IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic      [NumReq-1:0]             req_trans_valid_i,
    output logic      [NumReq-1:0]             req_trans_ready_o,
    input  hyper_tf_t [NumReq-1:0]             req_trans_i,
    input  logic      [NumReq-1:0][NumChips-1:0] req_trans_cs_i,
    input  logic      [NumReq-1:0]             req_tx_valid_i,
    output logic      [NumReq-1:0]             req_tx_ready_o,
    input  hyper_tx_t [NumReq-1:0]             req_tx_i,
    output logic      [NumReq-1:0]             req_rx_valid_o,
    input  logic      [NumReq-1:0]             req_rx_ready_i,
    output hyper_rx_t                          req_rx_o,
    output logic      [NumReq-1:0]             req_b_valid_o,
    input  logic      [NumReq-1:0]             req_b_ready_i,
    output logic                               req_b_error_o,
    output logic                               phy_trans_valid_o,
    input  logic                               phy_trans_ready_i,
    output hyper_tf_t                          phy_trans_o,
    output logic      [NumChips-1:0]           phy_trans_cs_o,
    output logic                               phy_tx_valid_o,
    input  logic                               phy_tx_ready_i,
    output hyper_tx_t                          phy_tx_o,
    input  logic                               phy_rx_valid_i,
    output logic                               phy_rx_ready_o,
    input  hyper_rx_t                          phy_rx_i,
    input  logic                               phy_b_valid_i,
    output logic                               phy_b_ready_o,
    input  logic                               phy_b_error_i,
    output logic      [IdxW-1:0]               owner_o,
`ifdef HYPERBUS_ARB_STATS_EN
    output logic      [NumReq-1:0][31:0]       grant_cnt_o,
`endif
    output logic                               busy_o
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [IdxW-1:0]     r_owner;
    logic [IdxW-1:0]     r_rr_ptr;
    hyper_tf_t           r_trans;
    logic [NumChips-1:0] r_cs;

    logic [NumReq-1:0]   w_grant;
    logic [IdxW-1:0]     w_grant_idx;
    logic                w_any;
    logic                w_load;
    logic                w_issue_hs;
    logic [IdxW-1:0]     w_owner_inc;

    hyperbus_rr_select #(
        .NumReq (NumReq)
    ) u_rr_select (
        .valid_i (req_trans_valid_i),
        .ptr_i   (r_rr_ptr),
        .grant_o (w_grant),
        .idx_o   (w_grant_idx)
    );

    assign w_any       = |w_grant;
    assign w_load      = (r_state == ARB_IDLE) && w_any;
    assign w_issue_hs  = (r_state == ARB_ISSUE) && phy_trans_ready_i;
    assign w_owner_inc = (r_owner == IdxW'(NumReq - 1)) ? '0 : r_owner + IdxW'(1);

    // State register plus the grant context captured in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_trans  <= '0;
            r_cs     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_owner <= w_grant_idx;
                r_trans <= req_trans_i[w_grant_idx];
                r_cs    <= req_trans_cs_i[w_grant_idx];
            end
            if (w_issue_hs) begin
                r_rr_ptr <= w_owner_inc;
            end
        end
    end

    // Next state and channel steering; everything is zero outside the owning state.
    always_comb begin
        w_state_nxt       = r_state;
        req_trans_ready_o = '0;
        req_tx_ready_o    = '0;
        req_rx_valid_o    = '0;
        req_rx_o          = '0;
        req_b_valid_o     = '0;
        req_b_error_o     = 1'b0;
        phy_trans_valid_o = 1'b0;
        phy_trans_o       = '0;
        phy_trans_cs_o    = '0;
        phy_tx_valid_o    = 1'b0;
        phy_tx_o          = '0;
        phy_rx_ready_o    = 1'b0;
        phy_b_ready_o     = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                phy_trans_valid_o = 1'b1;
                phy_trans_o       = r_trans;
                phy_trans_cs_o    = r_cs;
                // Requester ready is released only when the PHY accepts.
                if (phy_trans_ready_i) begin
                    req_trans_ready_o[r_owner] = 1'b1;
                    w_state_nxt = r_trans.write ? ARB_WRITE : ARB_READ;
                end
            end
            ARB_WRITE: begin
                phy_tx_valid_o          = req_tx_valid_i[r_owner];
                phy_tx_o                = req_tx_i[r_owner];
                req_tx_ready_o[r_owner] = phy_tx_ready_i;
                if (req_tx_valid_i[r_owner] && phy_tx_ready_i && req_tx_i[r_owner].last) begin
                    w_state_nxt = ARB_WAIT_B;
                end
            end
            ARB_WAIT_B: begin
                req_b_valid_o[r_owner] = phy_b_valid_i;
                req_b_error_o          = phy_b_error_i;
                phy_b_ready_o          = req_b_ready_i[r_owner];
                if (phy_b_valid_i && req_b_ready_i[r_owner]) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_READ: begin
                req_rx_valid_o[r_owner] = phy_rx_valid_i;
                req_rx_o                = phy_rx_i;
                phy_rx_ready_o          = req_rx_ready_i[r_owner];
                // Error beats pass through; only last releases ownership.
                if (phy_rx_valid_i && req_rx_ready_i[r_owner] && phy_rx_i.last) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign owner_o = r_owner;
    assign busy_o  = (r_state != ARB_IDLE);

`ifdef HYPERBUS_ARB_STATS_EN
    logic [NumReq-1:0][31:0] r_grant_cnt;

    // Saturating per-requester grant counters, bumped on each issue handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant_cnt <= '0;
        end else if (w_issue_hs && (r_grant_cnt[r_owner] != 32'hFFFF_FFFF)) begin
            r_grant_cnt[r_owner] <= r_grant_cnt[r_owner] + 32'd1;
        end
    end

    assign grant_cnt_o = r_grant_cnt;
`endif

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// tb_hyperbus_trans_arbiter: scoreboard bench for hyperbus_trans_arbiter.
// Stimulus pushes expected grants/beats into queues; a negedge monitor pops
// and compares on every PHY-side handshake.
module tb_hyperbus_trans_arbiter;
    import hyperbus_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned NC = 2;

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic      [NR-1:0]          req_trans_valid_i;
    logic      [NR-1:0]          req_trans_ready_o;
    hyper_tf_t [NR-1:0]          req_trans_i;
    logic      [NR-1:0][NC-1:0]  req_trans_cs_i;
    logic      [NR-1:0]          req_tx_valid_i;
    logic      [NR-1:0]          req_tx_ready_o;
    hyper_tx_t [NR-1:0]          req_tx_i;
    logic      [NR-1:0]          req_rx_valid_o;
    logic      [NR-1:0]          req_rx_ready_i;
    hyper_rx_t                   req_rx_o;
    logic      [NR-1:0]          req_b_valid_o;
    logic      [NR-1:0]          req_b_ready_i;
    logic                        req_b_error_o;
    logic                        phy_trans_valid_o;
    logic                        phy_trans_ready_i;
    hyper_tf_t                   phy_trans_o;
    logic      [NC-1:0]          phy_trans_cs_o;
    logic                        phy_tx_valid_o;
    logic                        phy_tx_ready_i;
    hyper_tx_t                   phy_tx_o;
    logic                        phy_rx_valid_i;
    logic                        phy_rx_ready_o;
    hyper_rx_t                   phy_rx_i;
    logic                        phy_b_valid_i;
    logic                        phy_b_ready_o;
    logic                        phy_b_error_i;
    logic      [0:0]             owner_o;
    logic                        busy_o;
`ifdef HYPERBUS_ARB_STATS_EN
    logic      [NR-1:0][31:0]    grant_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    hyperbus_trans_arbiter #(
        .NumReq   (NR),
        .NumChips (NC)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .req_trans_valid_i (req_trans_valid_i),
        .req_trans_ready_o (req_trans_ready_o),
        .req_trans_i       (req_trans_i),
        .req_trans_cs_i    (req_trans_cs_i),
        .req_tx_valid_i    (req_tx_valid_i),
        .req_tx_ready_o    (req_tx_ready_o),
        .req_tx_i          (req_tx_i),
        .req_rx_valid_o    (req_rx_valid_o),
        .req_rx_ready_i    (req_rx_ready_i),
        .req_rx_o          (req_rx_o),
        .req_b_valid_o     (req_b_valid_o),
        .req_b_ready_i     (req_b_ready_i),
        .req_b_error_o     (req_b_error_o),
        .phy_trans_valid_o (phy_trans_valid_o),
        .phy_trans_ready_i (phy_trans_ready_i),
        .phy_trans_o       (phy_trans_o),
        .phy_trans_cs_o    (phy_trans_cs_o),
        .phy_tx_valid_o    (phy_tx_valid_o),
        .phy_tx_ready_i    (phy_tx_ready_i),
        .phy_tx_o          (phy_tx_o),
        .phy_rx_valid_i    (phy_rx_valid_i),
        .phy_rx_ready_o    (phy_rx_ready_o),
        .phy_rx_i          (phy_rx_i),
        .phy_b_valid_i     (phy_b_valid_i),
        .phy_b_ready_o     (phy_b_ready_o),
        .phy_b_error_i     (phy_b_error_i),
        .owner_o           (owner_o),
`ifdef HYPERBUS_ARB_STATS_EN
        .grant_cnt_o       (grant_cnt_o),
`endif
        .busy_o            (busy_o)
    );

    typedef struct { logic r; logic wr; logic [31:0] addr; logic [1:0] cs; } g_t;
    typedef struct { logic r; logic [31:0] data; logic last; logic err; }     rx_t;
    typedef struct { logic r; logic [31:0] data; logic [3:0] strb; logic last; } tx_t;
    typedef struct { logic r; logic err; }                                    b_t;

    g_t  q_g[$];
    rx_t q_rx[$];
    tx_t q_tx[$];
    b_t  q_b[$];

    int n_vec = 0;
    int n_err = 0;
    int n_rx  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input logic r);
        oh = 2'b01 << r;
    endfunction

    // Scoreboard monitor: one pop per PHY-side handshake.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (phy_trans_valid_o && phy_trans_ready_i) begin
                if (q_g.size() == 0) check("grant_unexpected", 64'(q_g.size()), 64'(1));
                else begin
                    g_t g;
                    g = q_g.pop_front();
                    check("grant_owner", 64'(owner_o), 64'(g.r));
                    check("grant_ready", 64'(req_trans_ready_o), 64'(oh(g.r)));
                    check("grant_addr",  64'(phy_trans_o.address), 64'(g.addr));
                    check("grant_write", 64'(phy_trans_o.write), 64'(g.wr));
                    check("grant_cs",    64'(phy_trans_cs_o), 64'(g.cs));
                end
            end
            if (phy_tx_valid_o && phy_tx_ready_i) begin
                if (q_tx.size() == 0) check("tx_unexpected", 64'(q_tx.size()), 64'(1));
                else begin
                    tx_t t;
                    t = q_tx.pop_front();
                    check("tx_data",  64'(phy_tx_o.data), 64'(t.data));
                    check("tx_strb",  64'(phy_tx_o.strb), 64'(t.strb));
                    check("tx_last",  64'(phy_tx_o.last), 64'(t.last));
                    check("tx_ready", 64'(req_tx_ready_o), 64'(oh(t.r)));
                end
            end
            if (phy_rx_valid_i && phy_rx_ready_o) begin
                n_rx++;
                if (q_rx.size() == 0) check("rx_unexpected", 64'(q_rx.size()), 64'(1));
                else begin
                    rx_t x;
                    x = q_rx.pop_front();
                    check("rx_valid", 64'(req_rx_valid_o), 64'(oh(x.r)));
                    check("rx_data",  64'(req_rx_o.data), 64'(x.data));
                    check("rx_last",  64'(req_rx_o.last), 64'(x.last));
                    check("rx_error", 64'(req_rx_o.error), 64'(x.err));
                end
            end
            if (phy_b_valid_i && phy_b_ready_o) begin
                if (q_b.size() == 0) check("b_unexpected", 64'(q_b.size()), 64'(1));
                else begin
                    b_t b;
                    b = q_b.pop_front();
                    check("b_valid", 64'(req_b_valid_o), 64'(oh(b.r)));
                    check("b_error", 64'(req_b_error_o), 64'(b.err));
                end
            end
        end
    end

    // Waits for a handshake on channel ch (0 trans, 1 tx, 2 rx, 3 b); returns at posedge+1.
    task automatic wait_hs(input int ch, input string name, output int cyc);
        logic hit;
        hit = 1'b0;
        cyc = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_i);
            cyc++;
            case (ch)
                0:       hit = phy_trans_valid_o && phy_trans_ready_i;
                1:       hit = phy_tx_valid_o && phy_tx_ready_i;
                2:       hit = phy_rx_valid_i && phy_rx_ready_o;
                default: hit = phy_b_valid_i && phy_b_ready_o;
            endcase
            @(posedge clk_i); #1;
            if (hit) break;
        end
        check({name, "_hs_seen"}, 64'(hit), 64'(1));
    endtask

    task automatic issue(input logic r, input logic wr, input logic [31:0] addr,
                         input logic [15:0] burst, input logic [1:0] cs);
        hyper_tf_t t;
        int        cyc;
        t = '0;
        t.write   = wr;
        t.address = addr;
        t.burst   = burst;
        q_g.push_back('{r: r, wr: wr, addr: addr, cs: cs});
        req_trans_i[r]       = t;
        req_trans_cs_i[r]    = cs;
        req_trans_valid_i[r] = 1'b1;
        @(negedge clk_i);
        check("idle_no_trans_valid", 64'(phy_trans_valid_o), 64'(0));
        check("idle_no_trans_ready", 64'(req_trans_ready_o), 64'(0));
        @(posedge clk_i); #1;
        wait_hs(0, "issue", cyc);
        check("issue_latency", 64'(cyc), 64'(1));
        req_trans_valid_i = '0;
    endtask

    task automatic read_beats(input logic r, input int n, input logic [31:0] d0,
                              input int stall, input int err_beat);
        int cyc;
        for (int i = 0; i < n; i++) begin
            phy_rx_valid_i = 1'b1;
            phy_rx_i.data  = d0 + 32'(i);
            phy_rx_i.last  = (i == n - 1);
            phy_rx_i.error = (i == err_beat);
            q_rx.push_back('{r: r, data: d0 + 32'(i), last: (i == n - 1), err: (i == err_beat)});
            if (i == 0 && stall > 0) begin
                req_rx_ready_i = '0;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk_i);
                    check("rx_backpressure", 64'(phy_rx_ready_o), 64'(0));
                    @(posedge clk_i); #1;
                end
                req_rx_ready_i = '1;
            end
            @(negedge clk_i);
            check("busy_in_read", 64'(busy_o), 64'(1));
            @(posedge clk_i); #1;
            if (!(phy_rx_valid_i && phy_rx_ready_o)) ;
            // The handshake edge was the posedge just crossed; rewind not needed.
        end
        phy_rx_valid_i = 1'b0;
        phy_rx_i       = '0;
        cyc = 0;
    endtask

    task automatic write_beats(input logic r, input int n, input logic [31:0] d0);
        int cyc;
        for (int i = 0; i < n; i++) begin
            req_tx_valid_i[r]   = 1'b1;
            req_tx_i[r].data    = d0 + 32'(i);
            req_tx_i[r].strb    = 4'hF;
            req_tx_i[r].last    = (i == n - 1);
            q_tx.push_back('{r: r, data: d0 + 32'(i), strb: 4'hF, last: (i == n - 1)});
            wait_hs(1, "tx", cyc);
        end
        req_tx_valid_i = '0;
        req_tx_i       = '0;
    endtask

    task automatic b_resp(input logic r, input logic err);
        int cyc;
        phy_b_valid_i = 1'b1;
        phy_b_error_i = err;
        q_b.push_back('{r: r, err: err});
        wait_hs(3, "b", cyc);
        phy_b_valid_i = 1'b0;
        phy_b_error_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int base;
        logic done;
        rst_i             = 1'b1;
        req_trans_valid_i = '0;
        req_trans_i       = '0;
        req_trans_cs_i    = '0;
        req_tx_valid_i    = '0;
        req_tx_i          = '0;
        req_rx_ready_i    = '1;
        req_b_ready_i     = '1;
        phy_trans_ready_i = 1'b1;
        phy_tx_ready_i    = 1'b1;
        phy_rx_valid_i    = 1'b0;
        phy_rx_i          = '0;
        phy_b_valid_i     = 1'b0;
        phy_b_error_i     = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_busy",        64'(busy_o), 64'(0));
        check("rst_owner",       64'(owner_o), 64'(0));
        check("rst_trans_valid", 64'(phy_trans_valid_o), 64'(0));
        check("rst_trans_cs",    64'(phy_trans_cs_o), 64'(0));
        check("rst_rx_ready",    64'(phy_rx_ready_o), 64'(0));
        check("rst_b_ready",     64'(phy_b_ready_o), 64'(0));
        @(posedge clk_i); #1;

        // Single read, req0, burst of 4.
        issue(1'b0, 1'b0, 32'h0000_0100, 16'd4, 2'b01);
        read_beats(1'b0, 4, 32'h0000_00A0, 0, -1);
        @(negedge clk_i);
        check("busy_fall_after_read", 64'(busy_o), 64'(0));
        @(posedge clk_i); #1;

        // Single write, req1, 3 beats; early B and non-owner tx are held off.
        issue(1'b1, 1'b1, 32'h0000_0200, 16'd3, 2'b10);
        phy_b_valid_i     = 1'b1;
        req_tx_valid_i[0] = 1'b1;
        @(negedge clk_i);
        check("write_b_blocked",     64'(phy_b_ready_o), 64'(0));
        check("write_b_no_req",      64'(req_b_valid_o), 64'(0));
        check("write_tx_nonowner",   64'(req_tx_ready_o), 64'(2'b10));
        check("write_tx_idle_valid", 64'(phy_tx_valid_o), 64'(0));
        @(posedge clk_i); #1;
        phy_b_valid_i  = 1'b0;
        req_tx_valid_i = '0;
        write_beats(1'b1, 3, 32'h0000_00D0);
        b_resp(1'b1, 1'b0);

        // Both requesters held valid: grants alternate 0,1,0,1.
        req_trans_i[0].write   = 1'b0;
        req_trans_i[0].address = 32'h0000_0300;
        req_trans_i[0].burst   = 16'd1;
        req_trans_i[1].write   = 1'b0;
        req_trans_i[1].address = 32'h0000_0400;
        req_trans_i[1].burst   = 16'd1;
        req_trans_cs_i[0]      = 2'b01;
        req_trans_cs_i[1]      = 2'b10;
        for (int i = 0; i < 4; i++) begin
            q_g.push_back('{r: 1'(i % 2), wr: 1'b0, addr: (i % 2 == 0) ? 32'h300 : 32'h400,
                            cs: (i % 2 == 0) ? 2'b01 : 2'b10});
            q_rx.push_back('{r: 1'(i % 2), data: 32'h0000_00C0, last: 1'b1, err: 1'b0});
        end
        phy_rx_i.data     = 32'h0000_00C0;
        phy_rx_i.last     = 1'b1;
        phy_rx_i.error    = 1'b0;
        phy_rx_valid_i    = 1'b1;
        req_trans_valid_i = 2'b11;
        base = n_rx;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_i); #1;
            if (n_rx >= base + 4) begin
                done = 1'b1;
                break;
            end
        end
        check("alternate_done", 64'(done), 64'(1));
        req_trans_valid_i = '0;
        phy_rx_valid_i    = 1'b0;
        phy_rx_i          = '0;
        @(posedge clk_i); #1;

        // Read with 5 cycles of requester back-pressure and an error beat.
        issue(1'b0, 1'b0, 32'h0000_0500, 16'd3, 2'b01);
        read_beats(1'b0, 3, 32'h0000_00B0, 5, 1);

        // Reset in the middle of a write from req0 (rr_ptr is 1 going in).
        issue(1'b0, 1'b1, 32'h0000_0600, 16'd4, 2'b01);
        write_beats_partial: begin
            int cyc;
            req_tx_valid_i[0] = 1'b1;
            req_tx_i[0].data  = 32'h0000_00F0;
            req_tx_i[0].strb  = 4'hF;
            req_tx_i[0].last  = 1'b0;
            q_tx.push_back('{r: 1'b0, data: 32'h0000_00F0, strb: 4'hF, last: 1'b0});
            wait_hs(1, "tx_pre_reset", cyc);
        end
        req_tx_i[0].data = 32'h0000_00F1;
        phy_rx_valid_i   = 1'b1;
        phy_b_valid_i    = 1'b1;
        rst_i            = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_busy",     64'(busy_o), 64'(0));
        check("mid_rst_owner",    64'(owner_o), 64'(0));
        check("mid_rst_tx_valid", 64'(phy_tx_valid_o), 64'(0));
        check("mid_rst_tx_ready", 64'(req_tx_ready_o), 64'(0));
        check("mid_rst_rx_ready", 64'(phy_rx_ready_o), 64'(0));
        check("mid_rst_b_ready",  64'(phy_b_ready_o), 64'(0));
        check("mid_rst_rx_valid", 64'(req_rx_valid_o), 64'(0));
        check("mid_rst_b_valid",  64'(req_b_valid_o), 64'(0));
`ifdef HYPERBUS_ARB_STATS_EN
        check("mid_rst_cnt", 64'(grant_cnt_o[0]) | 64'(grant_cnt_o[1]), 64'(0));
`endif
        @(posedge clk_i); #1;
        req_tx_valid_i = '0;
        req_tx_i       = '0;
        phy_rx_valid_i = 1'b0;
        phy_b_valid_i  = 1'b0;

        // rr_ptr back at 0: with both valid, req0 wins.
        req_trans_i[1].write   = 1'b0;
        req_trans_i[1].address = 32'h0000_0800;
        req_trans_cs_i[1]      = 2'b10;
        req_trans_valid_i[1]   = 1'b1;
        issue(1'b0, 1'b0, 32'h0000_0810, 16'd1, 2'b01);
        read_beats(1'b0, 1, 32'h0000_0011, 0, -1);

        // Write with an error response to req1.
        issue(1'b1, 1'b1, 32'h0000_0700, 16'd1, 2'b10);
        write_beats(1'b1, 1, 32'h0000_00E0);
        b_resp(1'b1, 1'b1);

`ifdef HYPERBUS_ARB_STATS_EN
        issue(1'b0, 1'b0, 32'h0000_0900, 16'd1, 2'b01);
        read_beats(1'b0, 1, 32'h0000_0021, 0, -1);
        issue(1'b1, 1'b0, 32'h0000_0A00, 16'd1, 2'b10);
        read_beats(1'b1, 1, 32'h0000_0031, 0, -1);
        issue(1'b0, 1'b0, 32'h0000_0B00, 16'd1, 2'b01);
        read_beats(1'b0, 1, 32'h0000_0041, 0, -1);
        @(negedge clk_i);
        check("grant_cnt_req0", 64'(grant_cnt_o[0]), 64'(3));
        check("grant_cnt_req1", 64'(grant_cnt_o[1]), 64'(2));
        @(posedge clk_i); #1;
`endif

        repeat (2) @(posedge clk_i);
        #1;
        check("q_grant_drained", 64'(q_g.size()), 64'(0));
        check("q_rx_drained",    64'(q_rx.size()), 64'(0));
        check("q_tx_drained",    64'(q_tx.size()), 64'(0));
        check("q_b_drained",     64'(q_b.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hyperbus_trans_arbiter.md
Name: hyperbus_trans_arbiter

Overview:
- Shares one HyperBus PHY interface (trans/tx/rx/b channels, 32-bit dual-PHY or 16-bit single-PHY data) between NumReq requesters, e.g. AXI front-end and register/config DMA.
- Grants one whole transaction at a time in round-robin order.
- Holds ownership until the response completes, and steers tx/rx/b beats between the owner and the PHY interface.
- Sits between the requester front-ends and the PHY interface wrapper.

Parameters:
- NumReq, 2, number of requesters (>=2).
- NumChips, 2, chip-select width.
- hyper_tx_t, logic, tx beat type (data, strb, last).
- hyper_rx_t, logic, rx beat type (data, last, error).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_trans_valid_i  in  NumReq  per-requester transaction valid
- req_trans_ready_o  out  NumReq  per-requester transaction ready
- req_trans_i  in  NumReq x hyper_tf_t  transaction descriptor
- req_trans_cs_i  in  NumReq x NumChips  one-hot chip select
- req_tx_valid_i / req_tx_ready_o  in/out  NumReq  write-data handshake
- req_tx_i  in  NumReq x hyper_tx_t  write beat
- req_rx_valid_o / req_rx_ready_i  out/in  NumReq  read-data handshake
- req_rx_o  out  hyper_rx_t  read beat, broadcast to all requesters
- req_b_valid_o / req_b_ready_i  out/in  NumReq  write-response handshake
- req_b_error_o  out  1  write error, broadcast
- phy_trans_valid_o / phy_trans_ready_i, phy_trans_o (hyper_tf_t), phy_trans_cs_o (NumChips)  PHY-side transaction channel
- phy_tx_valid_o / phy_tx_ready_i, phy_tx_o  PHY-side tx channel
- phy_rx_valid_i / phy_rx_ready_o, phy_rx_i  PHY-side rx channel
- phy_b_valid_i / phy_b_ready_o, phy_b_error_i  PHY-side b channel
- owner_o  out  $clog2(NumReq)  current owner index (debug)
- busy_o  out  1  any state other than IDLE

Behaviour:
- Reset value of every output is 0; rr pointer resets to 0; FSM resets to IDLE.
- Reset mid-transaction drops ownership without draining the PHY; PHY and requesters must be reset together.
- FSM states: IDLE, ISSUE, WRITE, WAIT_B, READ.
- IDLE: select the first valid requester at or after rr_ptr, wrapping modulo NumReq. Register the owner and the trans/cs fields, then go to ISSUE next cycle. All req_trans_ready_o stay 0 in IDLE.
- ISSUE: phy_trans_valid_o=1 carrying the registered descriptor. On phy_trans_ready_i:
  - pulse req_trans_ready_o[owner] in that same cycle, so the requester's valid/data must be held stable since IDLE;
  - set rr_ptr=owner+1 (wrap);
  - go to WRITE if trans.write, else READ.
- Issue latency: request valid to phy_trans_valid_o is 1 cycle minimum.
- WRITE:
  - phy_tx_valid_o=req_tx_valid_i[owner]; phy_tx_o=req_tx_i[owner]; req_tx_ready_o[owner]=phy_tx_ready_i. Non-owners see ready 0.
  - A handshake with last=1 moves the FSM to WAIT_B.
  - B beats arriving during WRITE are not accepted (phy_b_ready_o=0).
- WAIT_B: req_b_valid_o[owner]=phy_b_valid_i; phy_b_ready_o=req_b_ready_i[owner]. On handshake go to IDLE.
- READ:
  - req_rx_valid_o[owner]=phy_rx_valid_i; phy_rx_ready_o=req_rx_ready_i[owner].
  - A handshake with rx.last=1 goes to IDLE.
  - rx.error is passed through and does not end ownership early.
- Outside the owning state, all phy ready/valid outputs to the PHY and all req channel outputs are 0. Stray phy_rx_valid_i/phy_b_valid_i are back-pressured, never dropped.
- Back-to-back: after IDLE re-entry the next grant costs 1 IDLE cycle plus 1 ISSUE cycle.
- Simultaneous requests: round-robin only, no priority. A requester whose valid drops in IDLE before selection is simply skipped.
- No combinational path from req_trans_valid_i to phy_trans_valid_o. The tx/rx/b steering paths are combinational.

Optional Feature:
- Macro: HYPERBUS_ARB_STATS_EN.
- When defined, the block adds output grant_cnt_o, NumReq x 32 bits. Counter [owner] increments on each ISSUE handshake and saturates at 0xFFFF_FFFF. Counters clear on rst_i.
- When undefined, the port and the counters are absent.

Decomposition:
- In hyperbus_pkg: arb_state_e enum (IDLE, ISSUE, WRITE, WAIT_B, READ). hyper_tf_t (with its write field) and hyper_cfg_t are reused as they are.
- Natural sub-module: hyperbus_rr_select, a purely combinational round-robin pick. Inputs are a valid vector and a pointer; outputs are a one-hot grant and an index.

Test Plan:
- Single read, req0, burst of 4 -> phy_trans_valid_o 1 cycle after valid; 4 rx beats reach req0 only; busy_o falls the cycle after the last beat.
- Single write, req1, 3 beats with strb 0xF -> tx forwarded unchanged, then B routed to req1 with b_error 0; req0 sees no valid at any point.
- req0 and req1 both held valid continuously -> grants alternate 0,1,0,1; owner_o matches; no back-to-back grants to the same requester.
- Read with phy_rx_ready back-pressure (req ready low for 5 cycles) -> phy_rx_ready_o low for the same 5 cycles; no beat lost or duplicated.
- rst_i asserted in the middle of WRITE -> the next cycle shows all outputs 0, state IDLE, rr_ptr 0.
- With HYPERBUS_ARB_STATS_EN, 3 grants to req0 and 2 to req1 -> grant_cnt_o reads {2,3}.
